// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states and prefetch queue entry.
package fetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: power-of-two circular buffer with push/pop/flush and occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  // Guards make an over/underflow request a no-op rather than corrupting pointers.
  assign w_push = i_push && (r_cnt != FULL);
  assign w_pop  = i_pop && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one-outstanding-request memory FSM feeding a prefetch queue, with redirect flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_data
);

  localparam int            CW   = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_issued_pc;
  logic [XLEN-1:0] w_redir_pc;
  logic [CW-1:0]   w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;

  assign w_redir_pc = redirect_pc & ~32'h3;

  // Redirect gates the request so a same-cycle acceptance never happens.
  assign imem_req  = reset && (r_state == IDLE) && (w_count < FULL) && !redirect;
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req && imem_ready;

  assign w_push      = (r_state == WAIT) && imem_rvalid && !redirect;
  assign w_pop       = inst_valid && inst_ready && !redirect;
  assign w_push_data = '{pc: r_issued_pc, instr: imem_rdata};

  fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .i_rst_n (reset),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign inst_valid = (w_count != '0);
  assign inst_pc    = inst_valid ? w_head.pc    : '0;
  assign inst_data  = inst_valid ? w_head.instr : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = WAIT;
      WAIT: begin
        if (imem_rvalid)   w_state_nxt = IDLE;
        else if (redirect) w_state_nxt = DISCARD;
      end
      DISCARD: if (imem_rvalid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_issued_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_issued_pc <= r_fetch_pc;
      if (redirect)      r_fetch_pc <= w_redir_pc;
      else if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized + directed bench for fetch_unit against a queue-based behavioural model.
module tb_fetch_unit;

  localparam int          QD   = 4;
  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_req, imem_ready, imem_rvalid, redirect;
  logic        inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst_pc, inst_data;

  logic        reset2, imem_req2, imem_ready2, imem_rvalid2, redirect2;
  logic        inst_valid2, inst_ready2;
  logic [31:0] imem_addr2, imem_rdata2, redirect_pc2, inst_pc2, inst_data2;

  fetch_unit #(.RESET_PC(RPC0), .QDEPTH(QD)) u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_pc(inst_pc), .inst_data(inst_data)
  );

  fetch_unit #(.RESET_PC(RPC2), .QDEPTH(QD)) u_dut2 (
    .clk(clk), .reset(reset2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready2), .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .redirect(redirect2), .redirect_pc(redirect_pc2), .inst_valid(inst_valid2),
    .inst_ready(inst_ready2), .inst_pc(inst_pc2), .inst_data(inst_data2)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Model: queue of expected {pc,data}, one outstanding-request flag with stale marker.
  logic [31:0] m_pcq[$];
  logic [31:0] m_dq[$];
  bit          m_out, m_stale;
  logic [31:0] m_pc, m_iss;
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  bit          dmode;
  logic [31:0] pops[$];
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return dmode ? (a ^ 32'h5A5A_0F0F) : a;
  endfunction

  task automatic cyc(input bit rst, input bit rdy, input bit irdy, input bit rd,
                     input logic [31:0] rpc, input int lat);
    bit ereq, acc, pop, rv;
    @(negedge clk);
    reset = rst; imem_ready = rdy; inst_ready = irdy; redirect = rd; redirect_pc = rpc;
    rv = mem_pend && (mem_cnt == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? mdata(mem_addr) : $urandom;
    #1;
    ereq = rst && !m_out && (m_pcq.size() < QD) && !rd;
    chk("imem_req",   32'(imem_req), 32'(ereq));
    chk("imem_addr",  imem_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(m_pcq.size() > 0));
    chk("inst_pc",    inst_pc,   (m_pcq.size() > 0) ? m_pcq[0] : 32'h0);
    chk("inst_data",  inst_data, (m_dq.size() > 0)  ? m_dq[0]  : 32'h0);
    obs_req = imem_req; obs_addr = imem_addr; obs_valid = inst_valid;
    if (rst && inst_valid && irdy && !rd) pops.push_back(inst_pc);
    if (!rst) begin
      m_pcq.delete(); m_dq.delete();
      m_out = 0; m_stale = 0; m_pc = RPC0; mem_pend = 0;
    end else begin
      acc = ereq && rdy;
      pop = (m_pcq.size() > 0) && irdy && !rd;
      if (rd) begin
        m_pcq.delete(); m_dq.delete();
      end else if (pop) begin
        void'(m_pcq.pop_front()); void'(m_dq.pop_front());
      end
      if (rv) begin
        if (!m_stale && !rd) begin
          m_pcq.push_back(m_iss); m_dq.push_back(mdata(mem_addr));
        end
        m_out = 0; m_stale = 0; mem_pend = 0;
      end else begin
        if (m_out && rd) m_stale = 1;
        if (mem_pend) mem_cnt--;
      end
      if (acc) begin
        m_out = 1; m_stale = 0; m_iss = m_pc;
        mem_pend = 1; mem_addr = m_pc; mem_cnt = lat - 1;
      end
      if (rd)       m_pc = rpc & ~32'h3;
      else if (acc) m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    pops.delete();
  endtask

  task automatic chk_pop(input string tag, input int idx, input logic [31:0] exp);
    chk(tag, (pops.size() > idx) ? pops[idx] : 32'hDEAD_DEAD, exp);
  endtask

  initial begin
    bit          pend2;
    logic [31:0] pa2;
    logic [31:0] pops2[$];
    logic [31:0] rpc;

    reset = 0; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect = 0; redirect_pc = 0; inst_ready = 0;
    reset2 = 0; imem_ready2 = 1; imem_rvalid2 = 0; imem_rdata2 = 0;
    redirect2 = 0; redirect_pc2 = 0; inst_ready2 = 1;
    m_out = 0; m_stale = 0; m_pc = RPC0; m_iss = 0;
    mem_pend = 0; mem_cnt = 0; mem_addr = 0; dmode = 0;

    // Streaming with a 1-cycle memory: PCs 0,4,8,C in order.
    do_reset();
    repeat (10) cyc(1, 1, 1, 0, 0, 1);
    chk_pop("stream0", 0, 32'h0);
    chk_pop("stream1", 1, 32'h4);
    chk_pop("stream2", 2, 32'h8);
    chk_pop("stream3", 3, 32'hC);

    // Consumer stalled: queue fills, requests stop, one pop releases addr 0x10.
    do_reset();
    repeat (14) cyc(1, 1, 0, 0, 0, 1);
    chk("full_req",   32'(obs_req), 32'h0);
    chk("full_valid", 32'(obs_valid), 32'h1);
    cyc(1, 1, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 1);
    chk("refill_req",  32'(obs_req), 32'h1);
    chk("refill_addr", obs_addr, 32'h10);
    repeat (14) cyc(1, 1, 1, 0, 0, 1);
    chk_pop("fill0", 0, 32'h0);
    chk_pop("fill3", 3, 32'hC);
    chk_pop("fill4", 4, 32'h10);

    // Redirect while waiting on a slow response: stale data dropped, restart at 0x100.
    do_reset();
    repeat (4) cyc(1, 1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 3);
    cyc(1, 1, 0, 1, 32'h100, 1);
    pops.delete();
    repeat (10) cyc(1, 1, 1, 0, 0, 1);
    chk_pop("redir_wait", 0, 32'h100);
    chk_pop("redir_wait1", 1, 32'h104);

    // Redirect coinciding with rvalid for PC 4: that instruction never surfaces.
    do_reset();
    repeat (3) cyc(1, 1, 1, 0, 0, 1);
    cyc(1, 1, 1, 1, 32'h200, 1);
    repeat (8) cyc(1, 1, 1, 0, 0, 1);
    chk_pop("redir_rv0", 0, 32'h0);
    chk_pop("redir_rv1", 1, 32'h200);

    // Reset asserted mid-WAIT with two queued entries.
    do_reset();
    repeat (4) cyc(1, 1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 3);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    chk("rst_valid", 32'(obs_valid), 32'h0);
    chk("rst_req",   32'(obs_req), 32'h0);
    cyc(1, 1, 0, 0, 0, 1);
    chk("rel_req",  32'(obs_req), 32'h1);
    chk("rel_addr", obs_addr, RPC0);

    // Random traffic: latencies, stalls, redirects (some near the wrap point), resets.
    dmode = 1;
    for (int i = 0; i < 2500; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 1), ($urandom_range(0, 7) == 0), rpc, $urandom_range(1, 4));
    end

    // Second instance: reset PC near the top of the address space must wrap to 0.
    pend2 = 0; pa2 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) reset2 = 1;
      imem_rvalid2 = pend2; imem_rdata2 = pa2; pend2 = 0;
      #1;
      if (i == 0) begin
        chk("rpc_req",  32'(imem_req2), 32'h1);
        chk("rpc_addr", imem_addr2, RPC2);
      end
      if (inst_valid2) begin
        pops2.push_back(inst_pc2);
        chk("wrap_data", inst_data2, inst_pc2);
      end
      if (imem_req2 && imem_ready2) begin
        pend2 = 1; pa2 = imem_addr2;
      end
    end
    chk("wrap_n",  32'(pops2.size() >= 3), 32'h1);
    chk("wrap0", (pops2.size() > 0) ? pops2[0] : 32'hDEAD_DEAD, 32'hFFFF_FFF8);
    chk("wrap1", (pops2.size() > 1) ? pops2[1] : 32'hDEAD_DEAD, 32'hFFFF_FFFC);
    chk("wrap2", (pops2.size() > 2) ? pops2[2] : 32'hDEAD_DEAD, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter QDEPTH, default 4: prefetch queue entries; legal values are powers of two, 2..8.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous and active-low (0 = reset), sampled on clk rising edge.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch byte address, always word aligned.
REQ-007 imem_ready  input  1  memory accepts request when imem_req && imem_ready.
REQ-008 imem_rvalid  input  1  response valid; exactly one per accepted request, at least 1 cycle after acceptance.
REQ-009 imem_rdata  input  32  instruction word returned.
REQ-010 redirect  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  input  32  new fetch address, valid when redirect=1.
REQ-012 inst_valid  output  1  queue head holds an instruction.
REQ-013 inst_ready  input  1  consumer takes head when inst_valid && inst_ready.
REQ-014 inst_pc  output  32  PC of head instruction.
REQ-015 inst_data  output  32  head instruction word.

Function
REQ-016 fetch_pc register holds the next address to request; imem_addr = fetch_pc.
REQ-017 At most one request outstanding; states IDLE (none outstanding), WAIT (one outstanding, live), DISCARD (one outstanding, stale).
REQ-018 IDLE: imem_req=1 when queue count < QDEPTH; on acceptance go to WAIT and fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-019 WAIT: imem_req=0; on imem_rvalid push {issued PC, imem_rdata} into queue, return to IDLE.
REQ-020 Issued PC is captured at acceptance; inst_pc equals the address presented when that request was accepted.
REQ-021 Queue outputs are driven from the head entry; inst_valid rises the cycle after the pushing imem_rvalid (1-cycle response-to-output latency).
REQ-022 Simultaneous push and pop in one cycle are both performed; count unchanged; pop at full is legal alongside push.
REQ-023 No push occurs when full; the count<QDEPTH issue rule guarantees space for every accepted response.
REQ-024 redirect=1: queue emptied next cycle (inst_valid=0), fetch_pc := redirect_pc; a pop in the same cycle is ignored.
REQ-025 redirect in WAIT without same-cycle imem_rvalid -> DISCARD; in WAIT with same-cycle imem_rvalid -> response dropped, -> IDLE.
REQ-026 DISCARD: imem_req=0; on imem_rvalid drop data, -> IDLE; further redirects only update fetch_pc.
REQ-027 redirect in IDLE with same-cycle acceptance: acceptance is cancelled by gating imem_req low when redirect=1; fetch_pc := redirect_pc.
REQ-028 redirect_pc bits [1:0] are ignored (forced 0).

Reset
REQ-029 While reset=0: state=IDLE, fetch_pc=RESET_PC, queue empty, imem_req=0, inst_valid=0, inst_pc=0, inst_data=0.
REQ-030 First cycle with reset=1: imem_req=1, imem_addr=RESET_PC.
REQ-031 Reset mid-operation discards the queue and any outstanding response; a response arriving after reset release from a pre-reset request is a memory-side protocol violation and is not required to be handled.

Structure
REQ-032 Package fetch_pkg: XLEN=32, state enum {IDLE, WAIT, DISCARD}, queue entry type {pc, instr}.
REQ-033 One sub-module fetch_fifo (parameterised depth, push/pop/flush, count); FSM and fetch_pc live in fetch_unit.

Verification
REQ-034 Reset release, imem_ready=1, 1-cycle memory returning addr as data, inst_ready=1 -> inst_pc sequence 0,4,8,C with inst_data equal to inst_pc.
REQ-035 inst_ready=0 with memory always ready -> exactly 4 entries fill (PCs 0..C), imem_req held 0; one pop -> next request at addr 10.
REQ-036 Request at 8 accepted, redirect to 100 before rvalid, rvalid 3 cycles later -> response dropped, next request addr 100, first inst_pc=100.
REQ-037 redirect to 200 in same cycle as rvalid for addr 4 -> PC 4 never appears on inst_*; next inst_pc=200.
REQ-038 RESET_PC=FFFF_FFF8, run 3 fetches -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 reset=0 asserted while WAIT with 2 queued entries -> next cycle inst_valid=0, imem_req=0; after release imem_addr=RESET_PC.
